// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two data lanes (d0, d1)
// and an instruction-fetch requester. Fixed priority d0 > d1 > fetch, with
// a starvation counter that forces a fetch grant after STARVE_LIMIT data
// grants made while fetch is requesting.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to build a bus watchdog that
// abandons a transfer after TIMEOUT cycles without bus_ready, completes it
// with rdata=0 and pulses bus_err. Without the macro bus_err is tied low and
// a transfer waits for bus_ready indefinitely.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d0_req,
    input  logic [31:0] d0_addr,
    input  logic [31:0] d0_wdata,
    input  logic        d0_we,
    input  logic [3:0]  d0_be,
    input  logic        d1_req,
    input  logic [31:0] d1_addr,
    input  logic [31:0] d1_wdata,
    input  logic        d1_we,
    input  logic [3:0]  d1_be,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        d0_done,
    output logic        d1_done,
    output logic        if_done,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        stall_from_memory,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_D0   = 2'd1,
        OWN_D1   = 2'd2,
        OWN_IF   = 2'd3
    } owner_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Elaboration-time guard on parameter ranges.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("mem_bus_arbiter: STARVE_LIMIT must be 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT must be 1..255");
    end

    state_t      state_r, state_s;
    owner_t      owner_r, owner_s;
    owner_t      grant_s;
    logic [3:0]  starve_cnt_r, starve_cnt_s;
    logic        d0_elig_s, d1_elig_s, if_elig_s, starved_s;
    logic        tmo_hit_s;

    logic        bus_req_s;
    logic [31:0] bus_addr_s;
    logic        bus_we_s;
    logic [31:0] bus_wdata_s;
    logic [3:0]  bus_be_s;
    logic        d0_done_s, d1_done_s, if_done_s;
    logic [31:0] rdata_s;

    // A requester whose done is high this cycle is still holding its req;
    // masking it here prevents a second grant for the same transaction.
    assign d0_elig_s = d0_req & ~d0_done;
    assign d1_elig_s = d1_req & ~d1_done;
    assign if_elig_s = if_req & ~if_done;
    assign starved_s = (starve_cnt_r == STARVE_MAX);

    assign stall_from_memory = (d0_req & ~d0_done) | (d1_req & ~d1_done);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] tmo_cnt_r;

    assign tmo_hit_s = (state_r == ST_BUSY) && !bus_ready && (tmo_cnt_r == TMO_LAST);

    // Watchdog: counts BUSY cycles without bus_ready, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_r <= 8'd0;
        end else if (state_r == ST_BUSY && !bus_ready && !tmo_hit_s) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= 8'd0;
        end
    end

    // Error pulse coincides with the forced done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= tmo_hit_s;
        end
    end
`else
    assign tmo_hit_s = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // Arbitration: starved fetch first, then d0 > d1 > fetch.
    always_comb begin
        grant_s = OWN_NONE;
        if (state_r != ST_IDLE) begin
            grant_s = OWN_NONE;
        end else if (if_elig_s && starved_s) begin
            grant_s = OWN_IF;
        end else if (d0_elig_s) begin
            grant_s = OWN_D0;
        end else if (d1_elig_s) begin
            grant_s = OWN_D1;
        end else if (if_elig_s) begin
            grant_s = OWN_IF;
        end else begin
            grant_s = OWN_NONE;
        end
    end

    // Next-state and registered-output computation for the IDLE/BUSY FSM.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        starve_cnt_s = starve_cnt_r;
        bus_req_s    = bus_req;
        bus_addr_s   = bus_addr;
        bus_we_s     = bus_we;
        bus_wdata_s  = bus_wdata;
        bus_be_s     = bus_be;
        d0_done_s    = 1'b0;
        d1_done_s    = 1'b0;
        if_done_s    = 1'b0;
        rdata_s      = rdata;

        case (state_r)
            ST_IDLE: begin
                case (grant_s)
                    OWN_D0: begin
                        state_s     = ST_BUSY;
                        owner_s     = OWN_D0;
                        bus_req_s   = 1'b1;
                        bus_addr_s  = d0_addr;
                        bus_we_s    = d0_we;
                        bus_wdata_s = d0_we ? d0_wdata : 32'd0;
                        bus_be_s    = d0_be;
                        if (if_req && (starve_cnt_r < STARVE_MAX)) begin
                            starve_cnt_s = starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                    end
                    OWN_D1: begin
                        state_s     = ST_BUSY;
                        owner_s     = OWN_D1;
                        bus_req_s   = 1'b1;
                        bus_addr_s  = d1_addr;
                        bus_we_s    = d1_we;
                        bus_wdata_s = d1_we ? d1_wdata : 32'd0;
                        bus_be_s    = d1_be;
                        if (if_req && (starve_cnt_r < STARVE_MAX)) begin
                            starve_cnt_s = starve_cnt_r + 4'd1;
                        end else begin
                            starve_cnt_s = starve_cnt_r;
                        end
                    end
                    OWN_IF: begin
                        state_s      = ST_BUSY;
                        owner_s      = OWN_IF;
                        bus_req_s    = 1'b1;
                        bus_addr_s   = if_addr;
                        bus_we_s     = 1'b0;
                        bus_wdata_s  = 32'd0;
                        bus_be_s     = 4'hF;
                        starve_cnt_s = 4'd0;
                    end
                    default: begin
                        state_s = ST_IDLE;
                    end
                endcase
            end
            ST_BUSY: begin
                if (bus_ready || tmo_hit_s) begin
                    // Completion (normal or watchdog): release the bus and
                    // pulse the owner's done next cycle.
                    state_s     = ST_IDLE;
                    owner_s     = OWN_NONE;
                    bus_req_s   = 1'b0;
                    bus_addr_s  = 32'd0;
                    bus_we_s    = 1'b0;
                    bus_wdata_s = 32'd0;
                    bus_be_s    = 4'd0;
                    rdata_s     = bus_ready ? bus_rdata : 32'd0;
                    case (owner_r)
                        OWN_D0:  d0_done_s = 1'b1;
                        OWN_D1:  d1_done_s = 1'b1;
                        OWN_IF:  if_done_s = 1'b1;
                        default: d0_done_s = 1'b0;
                    endcase
                end else begin
                    state_s = ST_BUSY;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                owner_s   = OWN_NONE;
                bus_req_s = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_NONE;
            starve_cnt_r <= 4'd0;
            bus_req      <= 1'b0;
            bus_addr     <= 32'd0;
            bus_we       <= 1'b0;
            bus_wdata    <= 32'd0;
            bus_be       <= 4'd0;
            d0_done      <= 1'b0;
            d1_done      <= 1'b0;
            if_done      <= 1'b0;
            rdata        <= 32'd0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            starve_cnt_r <= starve_cnt_s;
            bus_req      <= bus_req_s;
            bus_addr     <= bus_addr_s;
            bus_we       <= bus_we_s;
            bus_wdata    <= bus_wdata_s;
            bus_be       <= bus_be_s;
            d0_done      <= d0_done_s;
            d1_done      <= d1_done_s;
            if_done      <= if_done_s;
            rdata        <= rdata_s;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter (STARVE_LIMIT=2, TIMEOUT=8).
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        d0_req, d1_req, if_req;
    logic [31:0] d0_addr, d0_wdata, d1_addr, d1_wdata, if_addr;
    logic        d0_we, d1_we;
    logic [3:0]  d0_be, d1_be;
    logic        d0_done, d1_done, if_done;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        stall_from_memory, bus_err;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] A0 = 32'h0000_0200;
    localparam logic [31:0] A1 = 32'h0000_0300;
    localparam logic [31:0] AF = 32'h0000_0400;

    // Expected {d0_done,d1_done,if_done} per cycle for back-to-back grants.
    localparam logic [2:0] T2_DONE [0:7] =
        '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    localparam logic [2:0] T3_DONE [0:12] =
        '{3'b000, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001,
          3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001};
    localparam logic [31:0] T3_ADDR [0:12] =
        '{32'd0, A0, 32'd0, A1, 32'd0, AF, 32'd0, A0, 32'd0, A1, 32'd0, AF, 32'd0};

    mem_bus_arbiter #(.STARVE_LIMIT(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .d0_req(d0_req), .d0_addr(d0_addr), .d0_wdata(d0_wdata), .d0_we(d0_we), .d0_be(d0_be),
        .d1_req(d1_req), .d1_addr(d1_addr), .d1_wdata(d1_wdata), .d1_we(d1_we), .d1_be(d1_be),
        .if_req(if_req), .if_addr(if_addr),
        .d0_done(d0_done), .d1_done(d1_done), .if_done(if_done), .rdata(rdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .stall_from_memory(stall_from_memory), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dones();
        return {29'd0, d0_done, d1_done, if_done};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; d0_req = 1'b0; d1_req = 1'b0; if_req = 1'b0;
        d0_addr = 32'd0; d0_wdata = 32'd0; d0_we = 1'b0; d0_be = 4'hF;
        d1_addr = 32'd0; d1_wdata = 32'd0; d1_we = 1'b0; d1_be = 4'hF;
        if_addr = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;

        // Reset state; stall follows its equation even during reset.
        tick(); tick();
        d0_req = 1'b1; #1;
        check("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_dones", dones(), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_stall", {31'd0, stall_from_memory}, 32'd1);
        tick();
        check("rst_no_grant", {31'd0, bus_req}, 32'd0);
        d0_req = 1'b0; rst = 1'b0;

        // Test 1: d0 read of 0x100, minimum latency.
        tick();
        d0_req = 1'b1; d0_addr = 32'h0000_0100; #1;
        check("t1_stall_c0", {31'd0, stall_from_memory}, 32'd1);
        tick();
        bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF; #1;
        check("t1_bus_req_c1", {31'd0, bus_req}, 32'd1);
        check("t1_bus_addr", bus_addr, 32'h0000_0100);
        check("t1_bus_we", {31'd0, bus_we}, 32'd0);
        check("t1_bus_wdata", bus_wdata, 32'd0);
        check("t1_stall_c1", {31'd0, stall_from_memory}, 32'd1);
        tick();
        #1;
        check("t1_done_c2", dones(), 32'd4);
        check("t1_rdata", rdata, 32'hDEAD_BEEF);
        check("t1_stall_c2", {31'd0, stall_from_memory}, 32'd0);
        d0_req = 1'b0; bus_ready = 1'b0;
        tick();
        #1;
        check("t1_no_double", {31'd0, bus_req}, 32'd0);
        check("t1_done_c3", dones(), 32'd0);

        // Test 2: all three raised together, ready always high.
        tick();
        d0_req = 1'b1; d0_addr = A0; d1_req = 1'b1; d1_addr = A1;
        if_req = 1'b1; if_addr = AF; bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
        #1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 2) d0_req = 1'b0;
            if (c == 4) d1_req = 1'b0;
            if (c == 6) if_req = 1'b0;
            #1;
            check($sformatf("t2_done_c%0d", c), dones(), {29'd0, T2_DONE[c]});
            check($sformatf("t2_bus_req_c%0d", c), {31'd0, bus_req},
                  ((c % 2) == 1 && c <= 5) ? 32'd1 : 32'd0);
            if (c == 5) begin
                check("t2_fetch_addr", bus_addr, AF);
                check("t2_fetch_we", {31'd0, bus_we}, 32'd0);
                check("t2_fetch_be", {28'd0, bus_be}, 32'h0000_000F);
            end
        end

        // Test 3: d0/d1 continuously requesting while fetch waits.
        tick();
        d0_req = 1'b1; d1_req = 1'b1; if_req = 1'b1; bus_ready = 1'b1;
        bus_rdata = 32'hA000_0000;
        #1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            bus_rdata = 32'hA000_0000 + 32'(c);
            if (c == 12) begin
                d0_req = 1'b0; d1_req = 1'b0; if_req = 1'b0;
            end
            #1;
            check($sformatf("t3_done_c%0d", c), dones(), {29'd0, T3_DONE[c]});
            if ((c % 2) == 1) begin
                check($sformatf("t3_addr_c%0d", c), bus_addr, T3_ADDR[c]);
            end
            if (T3_DONE[c] != 3'b000) begin
                check($sformatf("t3_rdata_c%0d", c), rdata, 32'hA000_0000 + 32'(c - 1));
            end
        end
        tick();
        bus_ready = 1'b0; #1;
        check("t3_idle", {31'd0, bus_req}, 32'd0);

        // Test 4: d1 store with partial byte enables, ready late.
        tick();
        d1_req = 1'b1; d1_addr = 32'h0000_0500; d1_wdata = 32'h1234_5678;
        d1_we = 1'b1; d1_be = 4'b0011; bus_rdata = 32'hCAFE_F00D;
        #1;
        check("t4_stall_c0", {31'd0, stall_from_memory}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) bus_ready = 1'b1;
            #1;
            check($sformatf("t4_bus_req_c%0d", c), {31'd0, bus_req}, 32'd1);
            check($sformatf("t4_bus_we_c%0d", c), {31'd0, bus_we}, 32'd1);
            check($sformatf("t4_bus_be_c%0d", c), {28'd0, bus_be}, 32'h0000_0003);
            check($sformatf("t4_bus_wdata_c%0d", c), bus_wdata, 32'h1234_5678);
            check($sformatf("t4_done_c%0d", c), dones(), 32'd0);
        end
        tick();
        d1_req = 1'b0; d1_we = 1'b0; d1_be = 4'hF; bus_ready = 1'b0; #1;
        check("t4_done", dones(), 32'd2);
        check("t4_bus_req_off", {31'd0, bus_req}, 32'd0);
        tick();
        #1;
        check("t4_done_after", dones(), 32'd0);

        // Test 6: bus never ready.
        tick();
        d0_req = 1'b1; d0_addr = 32'h0000_0600; bus_rdata = 32'h5555_AAAA; #1;
`ifdef MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 8; c++) begin
            tick();
            #1;
            check($sformatf("t6_bus_req_c%0d", c), {31'd0, bus_req}, 32'd1);
            check($sformatf("t6_err_c%0d", c), {31'd0, bus_err}, 32'd0);
            check($sformatf("t6_done_c%0d", c), dones(), 32'd0);
        end
        tick();
        d0_req = 1'b0; #1;
        check("t6_err", {31'd0, bus_err}, 32'd1);
        check("t6_done", dones(), 32'd4);
        check("t6_rdata", rdata, 32'd0);
        check("t6_bus_req_off", {31'd0, bus_req}, 32'd0);
        tick();
        #1;
        check("t6_err_after", {31'd0, bus_err}, 32'd0);
        check("t6_idle", {31'd0, bus_req}, 32'd0);
`else
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 12) bus_ready = 1'b1;
            #1;
            check($sformatf("t6_wait_c%0d", c), {31'd0, bus_req}, 32'd1);
            check($sformatf("t6_err_c%0d", c), {31'd0, bus_err}, 32'd0);
            check($sformatf("t6_done_c%0d", c), dones(), 32'd0);
        end
        tick();
        d0_req = 1'b0; bus_ready = 1'b0; #1;
        check("t6_done", dones(), 32'd4);
        check("t6_rdata", rdata, 32'h5555_AAAA);
        check("t6_err", {31'd0, bus_err}, 32'd0);
`endif

        // Test 5: reset during BUSY abandons the transfer.
        tick();
        d0_req = 1'b1; d0_addr = 32'h0000_0700; if_req = 1'b1; if_addr = 32'h0000_0800; #1;
        tick();
        #1;
        check("t5_busy", {31'd0, bus_req}, 32'd1);
        check("t5_starve_pre", {28'd0, dut.starve_cnt_r}, 32'd1);
        rst = 1'b1; if_req = 1'b0; bus_ready = 1'b1;
        tick();
        d0_req = 1'b0; rst = 1'b0; bus_ready = 1'b0; #1;
        check("t5_bus_req_off", {31'd0, bus_req}, 32'd0);
        check("t5_no_done", dones(), 32'd0);
        check("t5_starve", {28'd0, dut.starve_cnt_r}, 32'd0);
        check("t5_bus_addr", bus_addr, 32'd0);
        tick();
        #1;
        check("t5_no_done_c3", dones(), 32'd0);
        check("t5_idle_c3", {31'd0, bus_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
